// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding and the default operand width live here.
package serial_sub_pkg;

    localparam int SUB_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - bin.
// Produces the difference bit and the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Optional zero flag with SUB_ZERO_FLAG_EN.
module serial_sub4
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = SUB_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SUB_ZERO_FLAG_EN
   ,output logic             zero
`endif
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bq;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             b_next;
    logic [WIDTH:0]   res_cat;

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bq),
        .d    (d_bit),
        .bout (b_next)
    );

    // Concatenate then drop the LSB so WIDTH=1 needs no special case
    assign res_cat  = {d_bit, res};
    assign in_ready = (state == IDLE);

`ifdef SUB_ZERO_FLAG_EN
    logic zq;
    logic zero_r;

    assign zero = out_valid & zero_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            bq        <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zq        <= 1'b1;
            zero_r    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        bq    <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SUB_ZERO_FLAG_EN
                        zq    <= 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    res  <= res_cat[WIDTH:1];
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bq   <= b_next;
                    cnt  <= cnt + CNT_W'(1);
`ifdef SUB_ZERO_FLAG_EN
                    zq   <= zq & ~d_bit;
`endif
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes; later cycles wait for the consumer
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        diff      <= res;
                        borrow    <= bq;
`ifdef SUB_ZERO_FLAG_EN
                        zero_r    <= zq;
`endif
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4 at WIDTH 4, 1 and 8.
// Directed cases, exhaustive 4-bit sweep, random 1/8-bit samples.
module tb_serial_sub4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_v  [3];
    logic       out_ready_v [3];
    logic [7:0] a_v         [3];
    logic [7:0] b_v         [3];
    logic       in_ready_v  [3];
    logic       out_valid_v [3];
    logic       borrow_v    [3];
    logic [3:0] diff4;
    logic [0:0] diff1;
    logic [7:0] diff8;
`ifdef SUB_ZERO_FLAG_EN
    logic       zero_v      [3];
`endif

    int errors = 0;
    int checks = 0;
    int widths [3] = '{4, 1, 8};

    always #5 clk = ~clk;

    serial_sub4 #(.WIDTH(4)) u_w4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .a         (a_v[0][3:0]),
        .b         (b_v[0][3:0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .diff      (diff4),
        .borrow    (borrow_v[0])
`ifdef SUB_ZERO_FLAG_EN
       ,.zero      (zero_v[0])
`endif
    );

    serial_sub4 #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .a         (a_v[1][0:0]),
        .b         (b_v[1][0:0]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .diff      (diff1),
        .borrow    (borrow_v[1])
`ifdef SUB_ZERO_FLAG_EN
       ,.zero      (zero_v[1])
`endif
    );

    serial_sub4 #(.WIDTH(8)) u_w8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_v[2]),
        .in_ready  (in_ready_v[2]),
        .a         (a_v[2]),
        .b         (b_v[2]),
        .out_valid (out_valid_v[2]),
        .out_ready (out_ready_v[2]),
        .diff      (diff8),
        .borrow    (borrow_v[2])
`ifdef SUB_ZERO_FLAG_EN
       ,.zero      (zero_v[2])
`endif
    );

    function automatic logic [7:0] diff_of(input int k);
        case (k)
            0:       return {4'h0, diff4};
            1:       return {7'h00, diff1};
            default: return diff8;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance k; reference is plain modular arithmetic
    task automatic run_op(input int k, input logic [7:0] a,
                          input logic [7:0] b, input int stall,
                          input bit junk);
        int         w;
        int         n;
        int         da;
        logic [7:0] mask;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] exp_d;
        logic       exp_b;
        w     = widths[k];
        mask  = 8'((1 << w) - 1);
        ea    = a & mask;
        eb    = b & mask;
        da    = int'(ea) - int'(eb);
        exp_d = 8'(da) & mask;
        exp_b = (ea < eb);

        @(negedge clk);
        check("idle_ready", {7'h0, in_ready_v[k]}, 8'h01);
        a_v[k]        = a;
        b_v[k]        = b;
        in_valid_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        a_v[k]        = 8'h00;
        b_v[k]        = 8'h00;
        check("busy_ready", {7'h0, in_ready_v[k]}, 8'h00);

        n = 0;
        while (!out_valid_v[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 8'(n), 8'(w + 1));
        check("diff", diff_of(k), exp_d);
        check("borrow", {7'h0, borrow_v[k]}, {7'h0, exp_b});
`ifdef SUB_ZERO_FLAG_EN
        check("zero", {7'h0, zero_v[k]}, {7'h0, (exp_d == 8'h00)});
`endif

        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                in_valid_v[k] = 1'b1;
                a_v[k]        = 8'h01;
                b_v[k]        = 8'h01;
            end
            @(negedge clk);
            check("stall_valid", {7'h0, out_valid_v[k]}, 8'h01);
            check("stall_diff", diff_of(k), exp_d);
            check("stall_borrow", {7'h0, borrow_v[k]}, {7'h0, exp_b});
            check("stall_ready", {7'h0, in_ready_v[k]}, 8'h00);
        end
        in_valid_v[k]  = 1'b0;
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        check("drop_valid", {7'h0, out_valid_v[k]}, 8'h00);
        check("back_idle", {7'h0, in_ready_v[k]}, 8'h01);
        check("hold_diff", diff_of(k), exp_d);
`ifdef SUB_ZERO_FLAG_EN
        check("zero_gated", {7'h0, zero_v[k]}, 8'h00);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            a_v[k]         = 8'h00;
            b_v[k]         = 8'h00;
        end
        repeat (2) @(negedge clk);
        check("rst_in_ready", {7'h0, in_ready_v[0]}, 8'h01);
        check("rst_out_valid", {7'h0, out_valid_v[0]}, 8'h00);
        check("rst_diff", diff_of(0), 8'h00);
        check("rst_borrow", {7'h0, borrow_v[0]}, 8'h00);
        rst_n = 1'b1;

        run_op(0, 8'd9, 8'd3, 0, 1'b0);
        run_op(0, 8'd3, 8'd9, 0, 1'b0);
        run_op(0, 8'd0, 8'd1, 0, 1'b0);
        run_op(0, 8'd0, 8'd0, 0, 1'b0);
        run_op(0, 8'd5, 8'd5, 0, 1'b0);
        run_op(0, 8'd12, 8'd4, 3, 1'b1);
        run_op(0, 8'd9, 8'd3, 0, 1'b0);

        // Abort two cycles into SHIFT while diff still holds 6
        @(negedge clk);
        a_v[0]        = 8'h0D;
        b_v[0]        = 8'h02;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", {7'h0, out_valid_v[0]}, 8'h00);
        check("abort_diff", diff_of(0), 8'h00);
        check("abort_borrow", {7'h0, borrow_v[0]}, 8'h00);
        check("abort_ready", {7'h0, in_ready_v[0]}, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_ready", {7'h0, in_ready_v[0]}, 8'h01);
        run_op(0, 8'd7, 8'd2, 0, 1'b0);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(0, 8'(x), 8'(y), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)));
            end
        end

        run_op(1, 8'd0, 8'd1, 1, 1'b1);
        run_op(1, 8'd1, 8'd1, 0, 1'b0);
        repeat (8) begin
            run_op(1, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        run_op(2, 8'd0, 8'd1, 0, 1'b0);
        run_op(2, 8'd255, 8'd255, 0, 1'b0);
        repeat (40) begin
            run_op(2, 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
